// File: rtl/jtframe_prog_packer_if.sv
// SDRAM programming port: packer drives the request, the SDRAM controller
// answers with ack/rdy pulses.
interface jtframe_prog_packer_if;
   logic [21:0] prog_addr;
   logic [15:0] prog_data;
   logic [1:0]  prog_mask;
   logic [1:0]  prog_ba;
   logic        prog_we;
   logic        prog_rd;
   logic        prog_ack;
   logic        prog_rdy;

   modport master (
      output prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
      input  prog_ack, prog_rdy
   );

   modport slave (
      input  prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
      output prog_ack, prog_rdy
   );
endinterface

// File: rtl/jtframe_prog_packer.sv
// Maps MiST ioctl download bytes to SDRAM bank/word writes through a small FIFO.
// Optional macro JTFRAME_PROG_SWAB_EN: byte-swap lane selection for banks 1-3.
module jtframe_prog_packer #(
   parameter logic [24:0] BA1_START = 25'h040000,
   parameter logic [24:0] BA2_START = 25'h080000,
   parameter logic [24:0] BA3_START = 25'h0C0000,
   parameter logic [24:0] ROM_END   = 25'h100000,
   parameter int          FIFO_AW   = 2
) (
   input  logic                         clk_rom,
   input  logic                         rst_n,
   input  logic                         downloading,
   input  logic [24:0]                  ioctl_addr,
   input  logic [7:0]                   ioctl_data,
   input  logic                         ioctl_wr,
   jtframe_prog_packer_if.master        prog,
   output logic                         dwnld_busy,
   output logic                         ovf
);
   localparam int DEPTH = 1 << FIFO_AW;

   typedef struct packed {
      logic [1:0]  ba;
      logic [21:0] addr;
      logic [1:0]  mask;
      logic [7:0]  data;
   } entry_t;

   typedef enum logic [1:0] { IDLE, ISSUE, WAIT } state_t;

   state_t              state, state_nxt;
   entry_t              mem [DEPTH];
   entry_t              new_entry, head;
   logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
   logic [FIFO_AW:0]    count;
   logic                empty, full, push, pop, drop, done;
   logic [22:0]         off;
   logic [1:0]          map_ba;
   logic                map_ok, lsb, dl_q;

   always_comb begin
      map_ok = 1'b1;
      map_ba = 2'd0;
      off    = ioctl_addr[22:0];
      if (ioctl_addr < BA1_START) begin
         map_ba = 2'd0;
      end else if (ioctl_addr < BA2_START) begin
         map_ba = 2'd1;
         off    = 23'(ioctl_addr - BA1_START);
      end else if (ioctl_addr < BA3_START) begin
         map_ba = 2'd2;
         off    = 23'(ioctl_addr - BA2_START);
      end else if (ioctl_addr < ROM_END) begin
         map_ba = 2'd3;
         off    = 23'(ioctl_addr - BA3_START);
      end else begin
         map_ok = 1'b0;
      end
   end

`ifdef JTFRAME_PROG_SWAB_EN
   // big-endian 16-bit graphics ROMs live in banks 1-3
   assign lsb = off[0] ^ (map_ba != 2'd0);
`else
   assign lsb = off[0];
`endif

   assign new_entry = '{ba: map_ba, addr: off[22:1], mask: lsb ? 2'b01 : 2'b10, data: ioctl_data};
   assign head      = mem[rd_ptr];
   assign empty     = (count == '0);
   assign full      = count[FIFO_AW];
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push      = ioctl_wr & map_ok & (~full | pop);
   assign drop      = ioctl_wr & map_ok & full & ~pop;

   always_ff @(posedge clk_rom) begin
      if (push) mem[wr_ptr] <= new_entry;
   end

   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (FIFO_AW+1)'(1);
            2'b01:   count <= count - (FIFO_AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:  if (!empty) begin
                   pop       = 1'b1;
                   state_nxt = ISSUE;
                end
         ISSUE: if (prog.prog_ack) begin
                   done      = prog.prog_rdy;
                   state_nxt = prog.prog_rdy ? IDLE : WAIT;
                end
         WAIT:  if (prog.prog_rdy) begin
                   done      = 1'b1;
                   state_nxt = IDLE;
                end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         prog.prog_addr <= '0;
         prog.prog_data <= '0;
         prog.prog_mask <= 2'b11;
         prog.prog_ba   <= '0;
         prog.prog_we   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (pop) begin
            prog.prog_addr <= head.addr;
            prog.prog_data <= {head.data, head.data};
            prog.prog_mask <= head.mask;
            prog.prog_ba   <= head.ba;
            prog.prog_we   <= 1'b1;
         end else if (state == ISSUE && prog.prog_ack) begin
            prog.prog_we   <= 1'b0;
         end
         if (done) prog.prog_mask <= 2'b11;
      end
   end

   assign prog.prog_rd = 1'b0;

   always_ff @(posedge clk_rom or negedge rst_n) begin
      if (!rst_n) begin
         dwnld_busy <= 1'b0;
         ovf        <= 1'b0;
         dl_q       <= 1'b0;
      end else begin
         dwnld_busy <= downloading | ~empty | (state != IDLE);
         dl_q       <= downloading;
         if (drop)                     ovf <= 1'b1;
         else if (downloading & ~dl_q) ovf <= 1'b0;
      end
   end
endmodule

// File: tb/tb_jtframe_prog_packer.sv
// Directed bench for jtframe_prog_packer: mapping, handshake, FIFO overflow, reset.
module tb_jtframe_prog_packer;
   logic        clk_rom = 1'b0;
   logic        rst_n = 1'b0;
   logic        downloading = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_data = '0;
   logic        ioctl_wr = 1'b0;
   logic        dwnld_busy, ovf;
   int          checks = 0;
   int          errors = 0;

`ifdef JTFRAME_PROG_SWAB_EN
   localparam bit SWAB = 1'b1;
`else
   localparam bit SWAB = 1'b0;
`endif

   jtframe_prog_packer_if pif();

   jtframe_prog_packer dut (
      .clk_rom     (clk_rom),
      .rst_n       (rst_n),
      .downloading (downloading),
      .ioctl_addr  (ioctl_addr),
      .ioctl_data  (ioctl_data),
      .ioctl_wr    (ioctl_wr),
      .prog        (pif),
      .dwnld_busy  (dwnld_busy),
      .ovf         (ovf)
   );

   always #5 clk_rom = ~clk_rom;

   task automatic tick();
      @(posedge clk_rom); #1;
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic wait_we(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (pif.prog_we) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   // drive ack after ack_wait extra cycles; rdy either with ack or one cycle later
   task automatic service(input int ack_wait, input bit coincide);
      repeat (ack_wait) tick();
      pif.prog_ack = 1'b1; pif.prog_rdy = coincide;
      tick();
      pif.prog_ack = 1'b0; pif.prog_rdy = 1'b0;
      if (!coincide) begin
         pif.prog_rdy = 1'b1;
         tick();
         pif.prog_rdy = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ioctl_addr = 25'(i); ioctl_data = 8'h5A; ioctl_wr = i[0];
         tick();
      end
      checks++;
      if (pif.prog_we !== 1'b0 || pif.prog_mask !== 2'b11 || dwnld_busy !== 1'b0 || ovf !== 1'b0 || pif.prog_rd !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs we=%b mask=%b busy=%b ovf=%b rd=%b want 0 11 0 0 0",
                  pif.prog_we, pif.prog_mask, dwnld_busy, ovf, pif.prog_rd);
      end
      ioctl_wr = 1'b0;
      rst_n = 1'b1;
      repeat (3) tick();
      checks++;
      if (pif.prog_we !== 1'b0 || dwnld_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_stale we=%b busy=%b want 0 0", pif.prog_we, dwnld_busy);
      end
   endtask

   task automatic test_single();
      bit ok;
      downloading = 1'b1;
      tick();
      send_byte(25'h000003, 8'hA5);
      checks++;
      if (pif.prog_we !== 1'b0) begin
         errors++; $display("FAIL single_we_early we=%b want 0", pif.prog_we);
      end
      tick();
      checks++;
      if (pif.prog_we !== 1'b1) begin
         errors++; $display("FAIL single_latency we=%b want 1", pif.prog_we);
      end
      checks++;
      if (pif.prog_ba !== 2'd0 || pif.prog_addr !== 22'h1 || pif.prog_data !== 16'hA5A5 || pif.prog_mask !== 2'b01) begin
         errors++;
         $display("FAIL single_fields ba=%0d addr=%h data=%h mask=%b want 0 1 a5a5 01",
                  pif.prog_ba, pif.prog_addr, pif.prog_data, pif.prog_mask);
      end
      checks++;
      if (dwnld_busy !== 1'b1) begin
         errors++; $display("FAIL single_busy busy=%b want 1", dwnld_busy);
      end
      downloading = 1'b0;
      wait_we(ok);
      service(0, 1'b0);
      checks++;
      if (pif.prog_we !== 1'b0 || pif.prog_mask !== 2'b11 || pif.prog_addr !== 22'h1 || dwnld_busy !== 1'b1) begin
         errors++;
         $display("FAIL single_done we=%b mask=%b addr=%h busy=%b want 0 11 1 1",
                  pif.prog_we, pif.prog_mask, pif.prog_addr, dwnld_busy);
      end
      tick();
      checks++;
      if (dwnld_busy !== 1'b0) begin
         errors++; $display("FAIL single_busy_fall busy=%b want 0", dwnld_busy);
      end
   endtask

   task automatic test_banks();
      logic [24:0] a  [5] = '{25'h040000, 25'h080001, 25'h0C0002, 25'h0FFFFF, 25'h100000};
      logic [1:0]  eb [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
      logic [21:0] ea [4] = '{22'h0, 22'h0, 22'h1, 22'h1FFFF};
      bit          el [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [1:0]  em;
      bit          ok;
      downloading = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) send_byte(a[i], 8'h11 * 8'(i + 1));
      downloading = 1'b0;
      for (int i = 0; i < 4; i++) begin
         em = (el[i] ^ SWAB) ? 2'b01 : 2'b10;
         wait_we(ok);
         checks++;
         if (!ok || pif.prog_ba !== eb[i] || pif.prog_addr !== ea[i] || pif.prog_mask !== em ||
             pif.prog_data !== {2{8'h11 * 8'(i + 1)}}) begin
            errors++;
            $display("FAIL bank_map[%0d] we=%b ba=%0d addr=%h mask=%b data=%h want 1 %0d %h %b %h",
                     i, ok, pif.prog_ba, pif.prog_addr, pif.prog_mask, pif.prog_data,
                     eb[i], ea[i], em, {2{8'h11 * 8'(i + 1)}});
         end
         service(0, 1'b0);
      end
      repeat (5) tick();
      checks++;
      if (pif.prog_we !== 1'b0 || ovf !== 1'b0 || dwnld_busy !== 1'b0) begin
         errors++;
         $display("FAIL bank_discard we=%b ovf=%b busy=%b want 0 0 0", pif.prog_we, ovf, dwnld_busy);
      end
   endtask

   task automatic test_stall();
      bit ok;
      int bad = 0;
      downloading = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) send_byte(25'h10 + 25'(i), 8'h60 + 8'(i));
      checks++;
      if (ovf !== 1'b1) begin
         errors++; $display("FAIL stall_ovf ovf=%b want 1", ovf);
      end
      for (int i = 0; i < 14; i++) begin
         if (pif.prog_we !== 1'b1 || pif.prog_addr !== 22'h8 || pif.prog_data !== 16'h6060 ||
             pif.prog_mask !== 2'b10 || pif.prog_ba !== 2'd0) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL stall_stable unstable_cycles=%0d want 0", bad);
      end
      downloading = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_we(ok);
         checks++;
         if (!ok || pif.prog_addr !== 22'(8 + i / 2) || pif.prog_data !== {2{8'h60 + 8'(i)}} ||
             pif.prog_mask !== (i[0] ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL stall_order[%0d] we=%b addr=%h data=%h mask=%b want 1 %h %h %b",
                     i, ok, pif.prog_addr, pif.prog_data, pif.prog_mask,
                     22'(8 + i / 2), {2{8'h60 + 8'(i)}}, (i[0] ? 2'b01 : 2'b10));
         end
         service(0, 1'b0);
      end
      repeat (4) tick();
      checks++;
      if (pif.prog_we !== 1'b0 || ovf !== 1'b1) begin
         errors++; $display("FAIL stall_tail we=%b ovf=%b want 0 1", pif.prog_we, ovf);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      downloading = 1'b1;
      tick();
      checks++;
      if (ovf !== 1'b0) begin
         errors++; $display("FAIL ovf_clear ovf=%b want 0", ovf);
      end
      send_byte(25'h20, 8'hAA);
      send_byte(25'h21, 8'hBB);
      wait_we(ok);
      checks++;
      if (!ok || pif.prog_addr !== 22'h10 || pif.prog_mask !== 2'b10 || pif.prog_data !== 16'hAAAA) begin
         errors++;
         $display("FAIL b2b_first we=%b addr=%h mask=%b data=%h want 1 10 10 aaaa",
                  ok, pif.prog_addr, pif.prog_mask, pif.prog_data);
      end
      pif.prog_ack = 1'b1; pif.prog_rdy = 1'b1;
      tick();
      pif.prog_ack = 1'b0; pif.prog_rdy = 1'b0;
      checks++;
      if (pif.prog_we !== 1'b0 || pif.prog_mask !== 2'b11) begin
         errors++; $display("FAIL b2b_coincide we=%b mask=%b want 0 11", pif.prog_we, pif.prog_mask);
      end
      tick();
      checks++;
      if (pif.prog_we !== 1'b1 || pif.prog_data !== 16'hBBBB || pif.prog_mask !== 2'b01 || pif.prog_addr !== 22'h10) begin
         errors++;
         $display("FAIL b2b_next we=%b data=%h mask=%b addr=%h want 1 bbbb 01 10",
                  pif.prog_we, pif.prog_data, pif.prog_mask, pif.prog_addr);
      end
      service(0, 1'b1);
      downloading = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset_mid();
      bit ok;
      downloading = 1'b1;
      tick();
      send_byte(25'h30, 8'hCC);
      send_byte(25'h31, 8'hDD);
      checks++;
      if (pif.prog_we !== 1'b1) begin
         errors++; $display("FAIL midrst_issue we=%b want 1", pif.prog_we);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (pif.prog_we !== 1'b0 || pif.prog_mask !== 2'b11 || dwnld_busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_async we=%b mask=%b busy=%b want 0 11 0", pif.prog_we, pif.prog_mask, dwnld_busy);
      end
      tick(); tick();
      rst_n = 1'b1;
      downloading = 1'b0;
      repeat (4) tick();
      checks++;
      if (pif.prog_we !== 1'b0 || dwnld_busy !== 1'b0) begin
         errors++; $display("FAIL midrst_empty we=%b busy=%b want 0 0", pif.prog_we, dwnld_busy);
      end
      downloading = 1'b1;
      tick();
      send_byte(25'h40, 8'hEE);
      wait_we(ok);
      checks++;
      if (!ok || pif.prog_addr !== 22'h20 || pif.prog_data !== 16'hEEEE || pif.prog_mask !== 2'b10 || pif.prog_ba !== 2'd0) begin
         errors++;
         $display("FAIL midrst_fresh we=%b addr=%h data=%h mask=%b ba=%0d want 1 20 eeee 10 0",
                  ok, pif.prog_addr, pif.prog_data, pif.prog_mask, pif.prog_ba);
      end
      service(0, 1'b0);
      downloading = 1'b0;
      repeat (3) tick();
      checks++;
      if (ovf !== 1'b0 || pif.prog_we !== 1'b0 || dwnld_busy !== 1'b0) begin
         errors++; $display("FAIL midrst_tail ovf=%b we=%b busy=%b want 0 0 0", ovf, pif.prog_we, dwnld_busy);
      end
   endtask

   initial begin
      pif.prog_ack = 1'b0;
      pif.prog_rdy = 1'b0;
      test_reset();
      test_single();
      test_banks();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jtframe_prog_packer.md
Name: jtframe_prog_packer

Overview:
- Sits between the MiST SPI download outputs (ioctl_addr/ioctl_data/ioctl_wr/downloading) and the SDRAM programming port of the board (prog_*).
- Maps each downloaded ROM byte to an SDRAM bank and word address, then buffers it in a small FIFO.
- Issues one masked byte write per entry using the prog_we/prog_ack/prog_rdy handshake.
- Produces dwnld_busy so the game/board hold reset until every byte has reached SDRAM.

Parameters:
- BA1_START, 25'h040000: first ioctl byte address of bank 1 region.
- BA2_START, 25'h080000: first byte address of bank 2 region.
- BA3_START, 25'h0C0000: first byte address of bank 3 region.
- ROM_END, 25'h100000: first byte address past ROM; bytes at or above it are discarded.
- FIFO_AW, 2: FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- clk_rom  in  1  SDRAM/programming clock
- rst_n  in  1  asynchronous active-low reset
- downloading  in  1  high while the SPI ROM transfer is active
- ioctl_addr  in  25  byte address of the current byte
- ioctl_data  in  8  byte value
- ioctl_wr  in  1  single-cycle strobe: byte valid
- prog_addr  out  22  SDRAM word address within the bank
- prog_data  out  16  byte replicated on both lanes, {d,d}
- prog_mask  out  2  active-low lane mask; 2'b10 = low lane written, 2'b01 = high lane written
- prog_ba  out  2  SDRAM bank
- prog_we  out  1  write request
- prog_rd  out  1  always 0
- prog_ack  in  1  one-cycle pulse: request accepted by the SDRAM controller
- prog_rdy  in  1  one-cycle pulse: write completed
- dwnld_busy  out  1  download or write-back still in progress
- ovf  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty; state IDLE; all outputs 0; prog_mask = 2'b11. Deassertion takes effect at the next clk_rom edge. Reset mid-write drops the request immediately; the SDRAM controller's own reset covers the rest.
- Mapping, evaluated on an ioctl_wr cycle. The region is selected by comparison in order:
  - addr < BA1_START: ba=0, off=addr
  - addr < BA2_START: ba=1, off=addr-BA1_START
  - addr < BA3_START: ba=2, off=addr-BA2_START
  - addr < ROM_END: ba=3, off=addr-BA3_START
  - otherwise: discarded; no push and ovf is not affected.
- Entry contents: prog_addr = off[22:1], zero-extended to 22 bits; mask = off[0] ? 2'b01 : 2'b10; data = {d,d}.
- Push: an ioctl_wr with a mapped address writes the entry at the clock edge. If the FIFO is full and no pop happens in the same cycle, the byte is dropped and ovf is set. A push and a pop in the same cycle while full are legal: count is unchanged and no drop occurs.
- ovf clears on the rising edge of downloading and is otherwise sticky.
- FSM:
  - IDLE: if the FIFO is not empty, pop and register prog_addr/prog_data/prog_mask/prog_ba, set prog_we=1, go to ISSUE.
  - ISSUE: hold prog_we and all prog_* fields stable until prog_ack. On ack, prog_we=0 at the next edge; go to WAIT.
  - WAIT: on prog_rdy go to IDLE. If ack and rdy arrive in the same cycle, go straight to IDLE.
- After a write completes (in WAIT, or in ISSUE when ack and rdy coincide), prog_mask returns to 2'b11. prog_addr/prog_data/prog_ba keep their last value.
- Latency: ioctl_wr at edge N into an empty FIFO gives prog_we=1 after edge N+1. Minimum throughput is one byte per 3 cycles (ack and rdy both one cycle later).
- dwnld_busy is registered: downloading | fifo_not_empty | (state != IDLE). It falls the cycle after the last prog_rdy once downloading is already low.
- Bytes arriving after downloading falls are still accepted if mapped.

Optional Feature:
- JTFRAME_PROG_SWAB_EN: when defined, off[0] is inverted for bank 1–3 regions only (16-bit big-endian graphics ROMs). The mask for those banks becomes off[0] ? 2'b10 : 2'b01; bank 0 is unchanged. The address mapping is unaffected.
- When undefined, all banks use the mapping above.

Test Plan:
- Reset with ioctl_wr pulsing -> no prog_we, prog_mask=2'b11, dwnld_busy=0, ovf=0.
- Byte 8'hA5 at addr 25'h000003, ack 1 cycle and rdy 2 cycles after prog_we -> prog_ba=0, prog_addr=22'h1, prog_data=16'hA5A5, prog_mask=2'b01. prog_we rises 2 edges after ioctl_wr and dwnld_busy falls after rdy once downloading=0.
- Bytes at 25'h040000, 25'h080001, 25'h0C0002, 25'h100000 -> writes (ba1,addr0,mask 10), (ba2,addr0,mask 01), (ba3,addr1,mask 10), and the 4th is discarded. With JTFRAME_PROG_SWAB_EN the three masks become 01, 10, 01.
- Stall prog_ack for 20 cycles while streaming 6 bytes back-to-back (FIFO_AW=2) -> the first byte is in flight, 4 are buffered, the 6th is dropped with ovf=1, prog_* stay stable during the stall, and 5 writes happen in order.
- ack and rdy in the same cycle -> FSM returns to IDLE and the next FIFO entry issues on the following edge.
- Assert rst_n low during ISSUE -> prog_we=0 immediately and FIFO empty. A new download then clears nothing stale, and ovf=0 after the downloading rise.
